stack_based_alu: RTL and testbench
==================================

# stack_based_alu

Parameterised signed-integer stack machine: a 31-entry LIFO of N-bit two's-complement words with push, pop, add and multiply driven by a 3-bit opcode. Add and multiply read the top two entries in place and register the N-bit wrapped result with a signed-overflow flag. It is a self-contained compute leaf. The same RTL is instantiated at widths 4, 8, 16 and 32.

## Interface
- N, default 32: data word width in bits, N ≥ 2; all data is signed two's complement.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- opcode  input  3  operation select, sampled at rising clk.
- input_data  input  N  signed operand for PUSH.
- output_data  output  N  registered signed result (POP value or ADD/MUL result).
- overflow  output  1  registered; set when the last ADD/MUL result did not fit in N signed bits.
- sp  output  5  stack pointer = number of valid entries (0..31).

## Operation
- Opcodes:
  - 3'b110 PUSH.
  - 3'b111 POP.
  - 3'b100 ADD.
  - 3'b101 MUL.
  - 3'b0xx NOP.
- Storage: mem[0..30]; top of stack = mem[sp-1]; second = mem[sp-2].
- PUSH:
  - If sp < 31: mem[sp] ← input_data; sp ← sp+1.
  - If sp == 31 (full): ignored.
  - output_data and overflow hold.
- POP:
  - If sp > 0: output_data ← mem[sp-1]; sp ← sp-1; overflow ← 0.
  - If empty: ignored, all outputs hold.
- ADD:
  - If sp ≥ 2: output_data ← (top + second) truncated to N bits.
  - overflow ← 1 when both operands have equal sign and the result sign differs.
  - Stack contents and sp unchanged (operands are not consumed).
- MUL:
  - If sp ≥ 2: compute full 2N-bit signed product.
  - output_data ← low N bits.
  - overflow ← 1 unless bits [2N-1:N-1] of the product are all equal.
  - Stack and sp unchanged.
- ADD/MUL with sp < 2: no effect, outputs hold.
- NOP: nothing changes.
- Arithmetic is purely signed; no saturation, results wrap.

## Timing
- Fully synchronous except reset: one operation per clk cycle; no handshake, no busy state.
- Latency 1:
  - Result of the opcode sampled at edge k is visible on output_data/overflow/sp immediately after edge k.
  - A PUSH at edge k is usable by ADD/MUL at edge k+1 (back-to-back dependency, no bubble).
- Reset (rst low, any time, asynchronous):
  - sp ← 0, output_data ← 0, overflow ← 0.
  - Memory contents become don't-care (not observable because sp=0).
- Release of rst is synchronous to the next rising clk; no operation executes while rst is low.
- Reset mid-sequence discards the whole stack.

## Structure
- Shared package stack_alu_pkg:
  - Opcode localparams OP_PUSH=3'b110, OP_POP=3'b111, OP_ADD=3'b100, OP_MUL=3'b101.
  - Depth constant STACK_DEPTH=31.
  - SP width constant SP_W=5.
- Sub-module stack_alu_arith (combinational, parameter N):
  - Inputs: a, b.
  - Outputs: sum, sum_ovf, prod, prod_ovf.
- Top module holds the memory, sp and output registers plus the opcode decode.

## Test plan
- Reset: drive rst low mid-run → sp=0, output_data=0, overflow=0 asynchronously; POP afterward has no effect.
- Push 7, push 4, ADD:
  - N=4 → output −5, overflow 1.
  - N=8/16/32 → 11, overflow 0.
  - sp=2 after.
- Push 64, push 3, MUL:
  - N=8 → −64, overflow 1.
  - N=16/32 → 192, overflow 0.
- 16/32-bit: push 32767, push 1, ADD:
  - N=16 → −32768, overflow 1.
  - N=32 → 32768, overflow 0.
- N=32, two MUL cases:
  - push 1000000000, push 5, MUL → 705032704, overflow 1.
  - push 10654, push 25434, MUL → 270973836, overflow 0.
- Boundaries:
  - 31 pushes → sp=31; 32nd PUSH ignored.
  - POP returns the last pushed value, sp=30.
  - ADD with sp=1 holds outputs.
  - POP at sp=0 ignored.

Source files
------------

// File: rtl/stack_based_alu_pkg.sv
// ============================================================================
// stack_alu_pkg : shared opcodes and stack sizing for stack_based_alu | rev 1.0
// ============================================================================
`default_nettype none

package stack_alu_pkg;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;

  localparam int STACK_DEPTH = 31;
  localparam int SP_W        = 5;
endpackage

`default_nettype wire

// File: rtl/stack_based_alu_if.sv
// ============================================================================
// stack_based_alu_if : opcode/data bus of the stack ALU | rev 1.0
// ============================================================================
`default_nettype none

interface stack_based_alu_if #(
  parameter int N = 32
);
  import stack_alu_pkg::*;

  logic [2:0]      opcode;
  logic [N-1:0]    input_data;
  logic [N-1:0]    output_data;
  logic            overflow;
  logic [SP_W-1:0] sp;

  modport master (
    output opcode, input_data,
    input  output_data, overflow, sp
  );

  modport slave (
    input  opcode, input_data,
    output output_data, overflow, sp
  );
endinterface

`default_nettype wire

// File: rtl/stack_based_alu_arith.sv
// ============================================================================
// stack_alu_arith : wrapped signed add/multiply with overflow flags | rev 1.0
// ============================================================================
`default_nettype none

module stack_alu_arith #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         sum_ovf,
  output logic [N-1:0] prod,
  output logic         prod_ovf
);
  logic [2*N-1:0] w_full;
  logic [N:0]     w_hi;

  assign sum     = a + b;
  assign sum_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);

  // Sign-extended operands make an unsigned 2N-bit multiply equal the signed product.
  assign w_full   = {{N{a[N-1]}}, a} * {{N{b[N-1]}}, b};
  assign prod     = w_full[N-1:0];
  assign w_hi     = w_full[2*N-1:N-1];
  assign prod_ovf = !((&w_hi) || !(|w_hi));
endmodule

`default_nettype wire

// File: rtl/stack_based_alu.sv
// ============================================================================
// stack_based_alu : 31-deep signed LIFO with push/pop/add/mul | rev 1.0
// ============================================================================
`default_nettype none

module stack_based_alu
  import stack_alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst,
  stack_based_alu_if.slave  bus
);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [N-1:0]    mem_q [STACK_DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic [N-1:0]    out_q, out_d;
  logic            ovf_q, ovf_d;

  logic            w_can_push, w_can_pop, w_can_arith;
  logic [SP_W-1:0] w_top_idx, w_sec_idx;
  logic [N-1:0]    w_sum, w_prod;
  logic            w_sum_ovf, w_prod_ovf;

  assign w_can_push  = sp_q < SP_FULL;
  assign w_can_pop   = sp_q != '0;
  assign w_can_arith = sp_q >= SP_W'(2);
  assign w_top_idx   = w_can_pop   ? sp_q - SP_W'(1) : '0;
  assign w_sec_idx   = w_can_arith ? sp_q - SP_W'(2) : '0;

  stack_alu_arith #(.N(N)) u_arith (
    .a        (mem_q[w_top_idx]),
    .b        (mem_q[w_sec_idx]),
    .sum      (w_sum),
    .sum_ovf  (w_sum_ovf),
    .prod     (w_prod),
    .prod_ovf (w_prod_ovf)
  );

  // Writes during reset only touch slots that are invalid until overwritten by a later push.
  always_ff @(posedge clk) begin
    if (bus.opcode == OP_PUSH && w_can_push) begin
      mem_q[sp_q] <= bus.input_data;
    end
  end

  always_comb begin
    sp_d  = sp_q;
    out_d = out_q;
    ovf_d = ovf_q;
    case (bus.opcode)
      OP_PUSH: if (w_can_push) sp_d = sp_q + SP_W'(1);
      OP_POP: begin
        if (w_can_pop) begin
          out_d = mem_q[w_top_idx];
          sp_d  = sp_q - SP_W'(1);
          ovf_d = 1'b0;
        end
      end
      OP_ADD: begin
        if (w_can_arith) begin
          out_d = w_sum;
          ovf_d = w_sum_ovf;
        end
      end
      OP_MUL: begin
        if (w_can_arith) begin
          out_d = w_prod;
          ovf_d = w_prod_ovf;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q  <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.sp          = sp_q;
  assign bus.output_data = out_q;
  assign bus.overflow    = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_stack_based_alu.sv
// ============================================================================
// tb_stack_based_alu : four widths driven in lockstep against a queue model | rev 1.0
// ============================================================================
`default_nettype none

module tb_stack_based_alu;
  localparam logic [2:0] PUSH = 3'b110;
  localparam logic [2:0] POP  = 3'b111;
  localparam logic [2:0] ADD  = 3'b100;
  localparam logic [2:0] MUL  = 3'b101;
  localparam logic [2:0] NOP  = 3'b000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  op = NOP;
  logic [31:0] din = '0;

  int checks = 0;
  int errors = 0;

  int     W [4] = '{4, 8, 16, 32};
  longint mq [4][$];
  longint mout [4];
  bit     movf [4];

  always #5 clk = ~clk;

  stack_based_alu_if #(.N(4))  if4 ();
  stack_based_alu_if #(.N(8))  if8 ();
  stack_based_alu_if #(.N(16)) if16 ();
  stack_based_alu_if #(.N(32)) if32 ();

  assign if4.opcode  = op;  assign if4.input_data  = din[3:0];
  assign if8.opcode  = op;  assign if8.input_data  = din[7:0];
  assign if16.opcode = op;  assign if16.input_data = din[15:0];
  assign if32.opcode = op;  assign if32.input_data = din;

  stack_based_alu #(.N(4))  dut4  (.clk(clk), .rst(rst_n), .bus(if4));
  stack_based_alu #(.N(8))  dut8  (.clk(clk), .rst(rst_n), .bus(if8));
  stack_based_alu #(.N(16)) dut16 (.clk(clk), .rst(rst_n), .bus(if16));
  stack_based_alu #(.N(32)) dut32 (.clk(clk), .rst(rst_n), .bus(if32));

  function automatic logic signed [63:0] dut_out(int k);
    logic signed [63:0] r;
    case (k)
      0:       r = $signed(if4.output_data);
      1:       r = $signed(if8.output_data);
      2:       r = $signed(if16.output_data);
      default: r = $signed(if32.output_data);
    endcase
    return r;
  endfunction

  function automatic logic dut_ovf(int k);
    case (k)
      0:       return if4.overflow;
      1:       return if8.overflow;
      2:       return if16.overflow;
      default: return if32.overflow;
    endcase
  endfunction

  function automatic logic [4:0] dut_sp(int k);
    case (k)
      0:       return if4.sp;
      1:       return if8.sp;
      2:       return if16.sp;
      default: return if32.sp;
    endcase
  endfunction

  // Reduce an exact integer to the signed value an w-bit register would hold.
  function automatic longint wrap(longint v, int w);
    logic [63:0] t;
    t = v;
    t = t << (64 - w);
    return $signed(t) >>> (64 - w);
  endfunction

  function automatic bit fits(longint v, int w);
    longint lim;
    lim = longint'(1) << (w - 1);
    return (v >= -lim) && (v < lim);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mout[k] = 0;
      movf[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(logic [2:0] o, longint d);
    longint top, sec, exact;
    for (int k = 0; k < 4; k++) begin
      case (o)
        PUSH: if (mq[k].size() < 31) mq[k].push_back(wrap(d, W[k]));
        POP: if (mq[k].size() > 0) begin
          mout[k] = mq[k].pop_back();
          movf[k] = 1'b0;
        end
        ADD, MUL: if (mq[k].size() >= 2) begin
          top   = mq[k][mq[k].size() - 1];
          sec   = mq[k][mq[k].size() - 2];
          exact = (o == ADD) ? top + sec : top * sec;
          mout[k] = wrap(exact, W[k]);
          movf[k] = !fits(exact, W[k]);
        end
        default: ;
      endcase
    end
  endfunction

  task automatic do_op(input logic [2:0] o, input longint d);
    @(negedge clk);
    op  = o;
    din = d[31:0];
    @(posedge clk);
    model_step(o, d);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    op    = NOP;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_sp(k) !== 5'd0 || dut_out(k) !== 64'sd0 || dut_ovf(k) !== 1'b0) begin
        errors++;
        $display("FAIL reset_init N=%0d got sp=%0d out=%0d ovf=%0b exp 0/0/0", W[k], dut_sp(k), dut_out(k), dut_ovf(k));
      end
    end
    @(negedge clk) rst_n = 1'b1;
    do_op(PUSH, 5);
    do_op(PUSH, 6);
    do_op(ADD, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_sp(k) !== 5'd0 || dut_out(k) !== 64'sd0 || dut_ovf(k) !== 1'b0) begin
        errors++;
        $display("FAIL reset_async N=%0d got sp=%0d out=%0d ovf=%0b exp 0/0/0", W[k], dut_sp(k), dut_out(k), dut_ovf(k));
      end
    end
    @(negedge clk);
    op  = PUSH;
    din = 32'd9;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_sp(k) !== 5'd0) begin
        errors++;
        $display("FAIL reset_held_push N=%0d got sp=%0d exp 0", W[k], dut_sp(k));
      end
    end
    @(negedge clk);
    op    = NOP;
    rst_n = 1'b1;
    do_op(POP, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_sp(k) !== 5'd0 || dut_out(k) !== 64'sd0 || dut_ovf(k) !== 1'b0) begin
        errors++;
        $display("FAIL reset_pop_empty N=%0d got sp=%0d out=%0d ovf=%0b exp 0/0/0", W[k], dut_sp(k), dut_out(k), dut_ovf(k));
      end
    end
  endtask

  // Pushes a, b then runs o; compares against the model and, where valid, a literal expectation.
  task automatic test_directed(input string tag, input longint a, input longint b, input logic [2:0] o,
                               input bit use_lit [4], input longint lit_out [4], input bit lit_ovf [4]);
    apply_reset();
    do_op(PUSH, a);
    do_op(PUSH, b);
    do_op(o, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_sp(k) !== 5'(mq[k].size())) begin
        errors++;
        $display("FAIL %s_sp N=%0d got %0d exp %0d", tag, W[k], dut_sp(k), mq[k].size());
      end
      checks++;
      if (dut_out(k) !== mout[k] || dut_ovf(k) !== movf[k]) begin
        errors++;
        $display("FAIL %s_model N=%0d got out=%0d ovf=%0b exp out=%0d ovf=%0b", tag, W[k], dut_out(k), dut_ovf(k), mout[k], movf[k]);
      end
      if (use_lit[k]) begin
        checks++;
        if (dut_out(k) !== lit_out[k] || dut_ovf(k) !== lit_ovf[k]) begin
          errors++;
          $display("FAIL %s_lit N=%0d got out=%0d ovf=%0b exp out=%0d ovf=%0b", tag, W[k], dut_out(k), dut_ovf(k), lit_out[k], lit_ovf[k]);
        end
      end
    end
  endtask

  task automatic test_boundaries();
    longint last;
    apply_reset();
    do_op(PUSH, 3);
    do_op(PUSH, 4);
    do_op(ADD, 0);
    do_op(POP, 0);
    do_op(ADD, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_sp(k) !== 5'd1 || dut_out(k) !== 64'sd4 || dut_ovf(k) !== 1'b0) begin
        errors++;
        $display("FAIL add_sp1_hold N=%0d got sp=%0d out=%0d ovf=%0b exp 1/4/0", W[k], dut_sp(k), dut_out(k), dut_ovf(k));
      end
    end
    do_op(POP, 0);
    do_op(POP, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_sp(k) !== 5'd0 || dut_out(k) !== 64'sd3) begin
        errors++;
        $display("FAIL pop_empty_hold N=%0d got sp=%0d out=%0d exp 0/3", W[k], dut_sp(k), dut_out(k));
      end
    end
    last = 0;
    for (int i = 0; i < 31; i++) begin
      last = 100 + i * 7;
      do_op(PUSH, last);
    end
    do_op(PUSH, 12345);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_sp(k) !== 5'd31) begin
        errors++;
        $display("FAIL full_push_ignored N=%0d got sp=%0d exp 31", W[k], dut_sp(k));
      end
    end
    do_op(POP, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_sp(k) !== 5'd30 || dut_out(k) !== wrap(last, W[k])) begin
        errors++;
        $display("FAIL full_pop N=%0d got sp=%0d out=%0d exp 30/%0d", W[k], dut_sp(k), dut_out(k), wrap(last, W[k]));
      end
    end
  endtask

  task automatic test_random(input int cycles);
    logic [2:0] o;
    longint     d;
    int         r;
    apply_reset();
    for (int i = 0; i < cycles; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      o = PUSH;
      else if (r <= 5) o = POP;
      else if (r == 6) o = ADD;
      else if (r == 7) o = MUL;
      else             o = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) d = longint'($signed(32'($urandom)));
      else                          d = longint'($urandom_range(0, 20)) - 10;
      do_op(o, d);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dut_sp(k) !== 5'(mq[k].size()) || dut_out(k) !== mout[k] || dut_ovf(k) !== movf[k]) begin
          errors++;
          $display("FAIL random_c%0d N=%0d got sp=%0d out=%0d ovf=%0b exp sp=%0d out=%0d ovf=%0b",
                   i, W[k], dut_sp(k), dut_out(k), dut_ovf(k), mq[k].size(), mout[k], movf[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed("add_7_4", 7, 4, ADD, '{1, 1, 1, 1}, '{-5, 11, 11, 11}, '{1, 0, 0, 0});
    test_directed("mul_64_3", 64, 3, MUL, '{0, 1, 1, 1}, '{0, -64, 192, 192}, '{0, 1, 0, 0});
    test_directed("add_32767_1", 32767, 1, ADD, '{0, 0, 1, 1}, '{0, 0, -32768, 32768}, '{0, 0, 1, 0});
    test_directed("mul_1e9_5", 1000000000, 5, MUL, '{0, 0, 0, 1}, '{0, 0, 0, 705032704}, '{0, 0, 0, 1});
    test_directed("mul_10654_25434", 10654, 25434, MUL, '{0, 0, 0, 1}, '{0, 0, 0, 270973836}, '{0, 0, 0, 0});
    test_boundaries();
    test_random(400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
